// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the two-byte SPI command protocol: a command byte {rw, sel, ioc}
// followed by one data byte. The responder-side logic imports this package too.
package spi_cmd_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_SEL_HI = 6;
    localparam int CMD_SEL_LO = 5;
    localparam int CMD_IOC_HI = 4;
    localparam int CMD_IOC_LO = 0;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    localparam int BIT_MAX = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_GAP,
        ST_TRAIL,
        ST_CSHI
    } spi_state_e;

    function automatic logic [7:0] pack_cmd(input logic rw, input logic [1:0] sel,
                                            input logic [4:0] ioc);
        logic [7:0] cmd;
        cmd = '0;
        cmd[CMD_RW_BIT]            = rw;
        cmd[CMD_SEL_HI:CMD_SEL_LO] = sel;
        cmd[CMD_IOC_HI:CMD_IOC_LO] = ioc;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// Byte-wide SPI shift register: parallel load, MISO sample on SCK rise, shift on SCK fall.
// Timing is entirely up to the caller; this block only reacts to its strobes.
module spi_byte_shift (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       rise_i,
    input  logic       fall_i,
    input  logic       miso_i,
    output logic [7:0] data_o
);

    logic [7:0] data_q;
    logic       sample_q;

    // The bit sampled on the rise enters at the LSB on the following fall, so after
    // eight full bits the register holds the received byte MSB first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q   <= '0;
            sample_q <= 1'b0;
        end else begin
            if (rise_i) begin
                sample_q <= miso_i;
            end
            if (load_i) begin
                data_q <= load_data_i;
            end else if (fall_i) begin
                data_q <= {data_q[6:0], sample_q};
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator for the two-byte command protocol: request/response handshake on
// one side, registered SCK/MOSI/CS_b on the other, optional read-back of the data byte.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_HP  = 4
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rw,
    input  logic [1:0] i_req_sel,
    input  logic [4:0] i_req_ioc,
    input  logic [7:0] i_req_data,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_spi_sck,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_cs_b
);

    localparam int DIV_W = $clog2(CLK_DIV - 1) + 1;
    localparam int GAP_W = $clog2(GAP_HP - 1) + 1;
    localparam int BIT_W = $clog2(BIT_MAX) + 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_HP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_MAX);

    spi_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [GAP_W-1:0] gap_q;
    logic [BIT_W-1:0] bit_q;
    logic             byte_q;
    logic             rw_q;
    logic [7:0]       data_q;
    logic             sck_q;
    logic             mosi_q;
    logic             cs_b_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;

    logic             div_done;
    logic             gap_done;
    logic             last_bit;
    logic             accept;
    logic             rise_en;
    logic             fall_en;
    logic             shift_fall;
    logic             load_en;
    logic [7:0]       load_byte;
    logic [7:0]       shift_data;

    always_comb begin
        div_done = (div_q == DIV_MAX);
        div_d    = div_done ? '0 : div_q + 1'b1;
        gap_done = (gap_q == GAP_MAX);
        last_bit = (bit_q == '0);
        accept   = i_req_valid && ready_q;

        rise_en  = div_done && ((state_q == ST_LEAD)
                             || (state_q == ST_GAP && gap_done)
                             || (state_q == ST_SHIFT && !sck_q && !last_bit));
        fall_en  = div_done && (state_q == ST_SHIFT) && sck_q;

        // The last fall of the command byte swaps in the data byte instead of shifting;
        // whatever MISO delivered during the command byte is dropped there.
        load_en    = accept || (fall_en && last_bit && !byte_q);
        shift_fall = fall_en && !(last_bit && !byte_q);
        load_byte  = accept ? pack_cmd(i_req_rw, i_req_sel, i_req_ioc) : data_q;
    end

    spi_byte_shift u_shift (
        .clk_i       (i_sys_clk),
        .rst_i       (i_rst),
        .load_i      (load_en),
        .load_data_i (load_byte),
        .rise_i      (rise_en),
        .fall_i      (shift_fall),
        .miso_i      (i_spi_miso),
        .data_o      (shift_data)
    );

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            gap_q       <= '0;
            bit_q       <= '0;
            byte_q      <= 1'b0;
            rw_q        <= RD;
            data_q      <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_b_q      <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            div_q       <= div_d;
            unique case (state_q)
                ST_IDLE: begin
                    div_q <= '0;
                    if (accept) begin
                        state_q <= ST_LEAD;
                        ready_q <= 1'b0;
                        cs_b_q  <= 1'b0;
                        mosi_q  <= i_req_rw;
                        rw_q    <= i_req_rw;
                        data_q  <= (i_req_rw == WR) ? i_req_data : 8'h00;
                        byte_q  <= 1'b0;
                        bit_q   <= BIT_LAST;
                    end
                end
                ST_LEAD: begin
                    if (rise_en) begin
                        state_q <= ST_SHIFT;
                        sck_q   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (fall_en) begin
                        sck_q <= 1'b0;
                        if (!last_bit) begin
                            mosi_q <= shift_data[6];
                        end else begin
                            mosi_q <= byte_q ? 1'b0 : data_q[7];
                        end
                    end else if (rise_en) begin
                        sck_q <= 1'b1;
                        bit_q <= bit_q - 1'b1;
                    end else if (div_done) begin
                        state_q <= byte_q ? ST_TRAIL : ST_GAP;
                        gap_q   <= '0;
                    end
                end
                ST_GAP: begin
                    if (rise_en) begin
                        state_q <= ST_SHIFT;
                        sck_q   <= 1'b1;
                        byte_q  <= 1'b1;
                        bit_q   <= BIT_LAST;
                    end else if (div_done) begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_TRAIL: begin
                    if (div_done) begin
                        state_q     <= ST_CSHI;
                        cs_b_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (rw_q == WR) ? 8'h00 : shift_data;
                    end
                end
                ST_CSHI: begin
                    if (div_done) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_spi_sck   = sck_q;
    assign o_spi_mosi  = mosi_q;
    assign o_spi_cs_b  = cs_b_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two instances (N=2/GAP=4 and N=1/GAP=1), a pin-level
// monitor with a responder model, and frame-level expectations built from the protocol.
module tb_spi_cmd_master;

    localparam int DIV_A = 2;
    localparam int GAP_A = 4;
    localparam int DIV_B = 1;
    localparam int GAP_B = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_rw = '0;
    logic [1:0] req_ready, rsp_valid, sck, mosi, cs_b;
    logic [1:0] miso = '0;
    logic [1:0] req_sel  [2];
    logic [4:0] req_ioc  [2];
    logic [7:0] req_data [2];
    logic [7:0] rsp_data [2];

    always #5 clk = ~clk;

    spi_cmd_master #(.CLK_DIV(DIV_A), .GAP_HP(GAP_A)) u_dut_a (
        .i_sys_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_rw(req_rw[0]), .i_req_sel(req_sel[0]), .i_req_ioc(req_ioc[0]),
        .i_req_data(req_data[0]), .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]),
        .o_spi_sck(sck[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0]), .o_spi_cs_b(cs_b[0])
    );

    spi_cmd_master #(.CLK_DIV(DIV_B), .GAP_HP(GAP_B)) u_dut_b (
        .i_sys_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_rw(req_rw[1]), .i_req_sel(req_sel[1]), .i_req_ioc(req_ioc[1]),
        .i_req_data(req_data[1]), .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]),
        .o_spi_sck(sck[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1]), .o_spi_cs_b(cs_b[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ndiv(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int ngap(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    // Pin monitor and responder, per instance.
    int          cyc = 0;
    int          cs_len [2], last_cs_len [2], rises [2], negs [2];
    int          rsp_cnt [2], acc_cnt [2], accept_cyc [2], cs_fall_cyc [2], cs_rise_cyc [2];
    int          rsp_cyc [2], ready_cyc [2], terr [2], last_rise [2], last_chg [2];
    logic [15:0] bits [2];
    logic [7:0]  rsp_dat [2];
    logic [7:0]  resp_byte [2];
    bit          rsp_edge_ok [2];
    logic [1:0]  prev_cs = '1, prev_sck = '0, prev_mosi = '0, prev_ready = '1;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_b[i]) begin
                cs_fall_cyc[i] = cyc;
                cs_len[i]      = 0;
                rises[i]       = 0;
                negs[i]        = 0;
                bits[i]        = '0;
                last_rise[i]   = -1000;
                last_chg[i]    = cyc;
            end
            if (!cs_b[i]) cs_len[i]++;
            if (!prev_cs[i] && cs_b[i]) begin
                cs_rise_cyc[i] = cyc;
                last_cs_len[i] = cs_len[i];
            end
            if (!prev_sck[i] && sck[i]) begin
                rises[i]++;
                bits[i] = {bits[i][14:0], mosi[i]};
                if (cyc - last_chg[i] < ndiv(i)) terr[i]++;
                last_rise[i] = cyc;
            end
            if (!cs_b[i] && !prev_cs[i] && (mosi[i] != prev_mosi[i])) begin
                if (cyc - last_rise[i] < ndiv(i)) terr[i]++;
                last_chg[i] = cyc;
            end
            if (cs_b[i] && (sck[i] || mosi[i])) terr[i]++;
            if (prev_sck[i] && !sck[i]) begin
                negs[i]++;
                if (negs[i] >= 8 && negs[i] <= 15) miso[i] = resp_byte[i][15 - negs[i]];
                else                               miso[i] = 1'($urandom);
            end
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                rsp_cyc[i]     = cyc;
                rsp_dat[i]     = rsp_data[i];
                rsp_edge_ok[i] = cs_b[i] && !prev_cs[i];
            end
            if (!prev_ready[i] && req_ready[i]) ready_cyc[i] = cyc;
            if (req_valid[i] && req_ready[i]) begin
                acc_cnt[i]++;
                accept_cyc[i] = cyc;
            end
        end
        prev_cs    = cs_b;
        prev_sck   = sck;
        prev_mosi  = mosi;
        prev_ready = req_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble(input int i);
        req_rw[i]   = 1'($urandom);
        req_sel[i]  = 2'($urandom);
        req_ioc[i]  = 5'($urandom);
        req_data[i] = 8'($urandom);
    endtask

    task automatic start_req(input int i, input logic rw, input logic [1:0] sel,
                             input logic [4:0] ioc, input logic [7:0] data);
        int w = 0;
        while (!req_ready[i] && w < 500) begin
            tick();
            w++;
        end
        check_eq("ready_wait", 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_rw[i]    = rw;
        req_sel[i]   = sel;
        req_ioc[i]   = ioc;
        req_data[i]  = data;
        tick();
        req_valid[i] = 1'b0;
        scramble(i);
    endtask

    task automatic wait_rsp(input int i, input int t0);
        int w = 0;
        while (rsp_cnt[i] == t0 && w < 3000) begin
            tick();
            w++;
        end
        check_eq("rsp_timeout", 32'(rsp_cnt[i] != t0), 32'd1);
    endtask

    task automatic check_txn(input int i, input logic rw, input logic [1:0] sel,
                             input logic [4:0] ioc, input logic [7:0] data,
                             input logic [7:0] resp, input int t0r, input int t0a);
        logic [15:0] exp_bits;
        logic [7:0]  exp_rsp;
        repeat (ndiv(i) + 2) tick();
        exp_bits = {rw, sel, ioc, (rw ? data : 8'h00)};
        exp_rsp  = rw ? 8'h00 : resp;
        check_eq("mosi_frame",   32'(bits[i]), 32'(exp_bits));
        check_eq("sck_rises",    32'(rises[i]), 32'd16);
        check_eq("cs_low_len",   32'(last_cs_len[i]), 32'(ndiv(i) * (34 + ngap(i))));
        check_eq("cs_fall_lat",  32'(cs_fall_cyc[i] - accept_cyc[i]), 32'd1);
        check_eq("rsp_pulses",   32'(rsp_cnt[i] - t0r), 32'd1);
        check_eq("accepts",      32'(acc_cnt[i] - t0a), 32'd1);
        check_eq("rsp_at_cs_up", 32'(rsp_edge_ok[i]), 32'd1);
        check_eq("rsp_data",     32'(rsp_dat[i]), 32'(exp_rsp));
        check_eq("rsp_hold",     32'(rsp_data[i]), 32'(exp_rsp));
        check_eq("ready_gap",    32'(ready_cyc[i] - rsp_cyc[i]), 32'(ndiv(i)));
        check_eq("pin_timing",   32'(terr[i]), 32'd0);
    endtask

    task automatic do_txn(input int i, input logic rw, input logic [1:0] sel,
                          input logic [4:0] ioc, input logic [7:0] data,
                          input logic [7:0] resp, input bit poke);
        int t0r, t0a;
        resp_byte[i] = resp;
        t0r = rsp_cnt[i];
        t0a = acc_cnt[i];
        start_req(i, rw, sel, ioc, data);
        if (poke) begin
            repeat (3) tick();
            req_valid[i] = 1'b1;
            scramble(i);
            tick();
            tick();
            req_valid[i] = 1'b0;
        end
        wait_rsp(i, t0r);
        check_txn(i, rw, sel, ioc, data, resp, t0r, t0a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad, w, t0, a0, r0;
        logic [7:0] rb;
        for (int i = 0; i < 2; i++) scramble(i);
        repeat (3) tick();
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            tick();
            if (cs_b !== 2'b11 || sck !== 2'b00 || mosi !== 2'b00) bad++;
        end
        check_eq("idle_pins",     32'(bad), 32'd0);
        check_eq("idle_ready",    32'(req_ready), 32'd3);
        check_eq("idle_rsp_data", 32'(rsp_data[0]), 32'd0);
        check_eq("idle_no_rsp",   32'(rsp_cnt[0] + rsp_cnt[1]), 32'd0);

        do_txn(0, 1'b1, 2'd2, 5'h05, 8'hA5, 8'h3C, 1'b0);
        do_txn(0, 1'b0, 2'd1, 5'h1F, 8'hEE, 8'h5A, 1'b0);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++) begin
                do_txn(i, 1'($urandom), 2'($urandom), 5'($urandom), 8'($urandom),
                       8'($urandom), 1'($urandom));
            end
        end

        // Back-to-back: valid held high across two transactions.
        a0 = acc_cnt[0];
        r0 = rsp_cnt[0];
        rb = 8'($urandom);
        w  = 0;
        while (!req_ready[0] && w < 500) begin tick(); w++; end
        req_valid[0] = 1'b1;
        req_rw[0] = 1'b1; req_sel[0] = 2'd0; req_ioc[0] = 5'h11; req_data[0] = 8'h3C;
        w = 0;
        while (acc_cnt[0] == a0 && w < 500) begin tick(); w++; end
        resp_byte[0] = rb;
        req_rw[0] = 1'b0; req_sel[0] = 2'd1; req_ioc[0] = 5'h02; req_data[0] = 8'h99;
        w = 0;
        while (acc_cnt[0] == a0 + 1 && w < 500) begin tick(); w++; end
        req_valid[0] = 1'b0;
        check_eq("b2b_accepts",   32'(acc_cnt[0] - a0), 32'd2);
        check_eq("b2b_first_rsp", 32'(rsp_cnt[0] - r0), 32'd1);
        check_eq("b2b_acc_gap",   32'(accept_cyc[0] - rsp_cyc[0]), 32'(DIV_A));
        check_eq("b2b_cs_high",   32'((accept_cyc[0] + 1 - cs_rise_cyc[0]) >= DIV_A), 32'd1);
        wait_rsp(0, r0 + 1);
        check_txn(0, 1'b0, 2'd1, 5'h02, 8'h99, rb, r0 + 1, a0 + 1);

        // Reset in the middle of the data byte of a read.
        resp_byte[0] = 8'hC3;
        t0 = rsp_cnt[0];
        start_req(0, 1'b0, 2'd3, 5'h0A, 8'h77);
        w = 0;
        while (rises[0] < 12 && w < 500) begin tick(); w++; end
        check_eq("rst_in_byte1", 32'(rises[0] >= 12 && cs_b[0] == 1'b0), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_cs_b",     32'(cs_b[0]), 32'd1);
        check_eq("rst_sck",      32'(sck[0]), 32'd0);
        check_eq("rst_mosi",     32'(mosi[0]), 32'd0);
        check_eq("rst_ready",    32'(req_ready[0]), 32'd1);
        check_eq("rst_rsp_data", 32'(rsp_data[0]), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (200) tick();
        check_eq("rst_no_rsp", 32'(rsp_cnt[0] - t0), 32'd0);
        do_txn(0, 1'b0, 2'd3, 5'h0A, 8'h77, 8'hC3, 1'b0);

        // N=1 / GAP=1 corner with requests poked while busy.
        do_txn(1, 1'b0, 2'd2, 5'h01, 8'h00, 8'hFF, 1'b1);
        do_txn(1, 1'b0, 2'd0, 5'h1E, 8'hFF, 8'h00, 1'b1);
        do_txn(1, 1'b1, 2'd3, 5'h10, 8'h5C, 8'hFF, 1'b1);
        a0 = acc_cnt[1];
        repeat (20) tick();
        check_eq("busy_not_queued", 32'(acc_cnt[1] - a0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

FPGA-side SPI initiator for the two-byte command protocol used by the CaribouLite control interface. Each transaction is a command byte `{rw, sel[1:0], ioc[4:0]}` followed by a data byte. On a write the data byte is shifted out; on a read the responder's byte is captured from MISO. The block lets on-chip logic and the loopback self-test drive any responder of this protocol, and sits between a request/response handshake and the four SPI pins.

## Interface
Parameters:
- `CLK_DIV`, default 4: sys-clock cycles per SCK half-period, N ≥ 1.
- `GAP_HP`, default 4: SCK-low half-periods inserted between command and data byte, ≥ 1. Gives the responder time to fetch read data.

Ports:
- `i_sys_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  block idle and able to accept a request.
- `i_req_rw`  in  1  1 = write, 0 = read.
- `i_req_sel`  in  2  responder module select.
- `i_req_ioc`  in  5  I/O control / register code.
- `i_req_data`  in  8  write data; ignored on reads.
- `o_rsp_valid`  out  1  one-cycle completion pulse.
- `o_rsp_data`  out  8  read byte on reads; 0x00 on writes.
- `o_spi_sck`  out  1  SPI clock, mode 0 (idle low).
- `o_spi_mosi`  out  1  serial data out, MSB first.
- `i_spi_miso`  in  1  serial data in.
- `o_spi_cs_b`  out  1  active-low chip select.

## Operation
- Request accepted on a cycle where `i_req_valid && o_req_ready`. Command byte latched as `{i_req_rw, i_req_sel, i_req_ioc}`. Data byte latched as `i_req_rw ? i_req_data : 8'h00`.
- States:
  - IDLE: ready=1. On accept → LEAD.
  - LEAD: cs_b=0, SCK low, MOSI = cmd[7], N cycles → SHIFT(byte 0).
  - SHIFT: 8 bits. Each bit is SCK high for N cycles, then SCK low for N cycles.
    - MISO is sampled on the rising edge.
    - MOSI advances to the next bit on the falling edge.
    - After bit 0 of byte 0 → GAP. After bit 0 of byte 1 → TRAIL.
  - GAP: SCK low for GAP_HP·N cycles. MOSI = data[7] → SHIFT(byte 1).
  - TRAIL: SCK low for N cycles → CSHI. CS_b is raised and `o_rsp_valid` pulses on entry to CSHI.
  - CSHI: cs_b=1 for N cycles (minimum deselect time) → IDLE.
- MISO bits received during byte 1 are shifted into the rx register MSB first. `o_rsp_data` holds its value until the next response.
- Bits received during byte 0 are discarded.
- Requests presented while not ready are ignored and not queued. `i_req_*` may change after acceptance.
- Counters:
  - divider counts 0..N-1.
  - bit counter counts 7..0.
  - byte index is 0/1.
  - gap counter counts 0..GAP_HP-1.
  - Width of each counter is `$clog2` of its maximum value plus 1.

## Timing
- Reset values: `o_spi_cs_b`=1, `o_spi_sck`=0, `o_spi_mosi`=0, `o_req_ready`=1, `o_rsp_valid`=0, `o_rsp_data`=0x00, state IDLE.
- Assertion of `i_rst` mid-transaction behaves as follows:
  - pins return to reset values immediately;
  - no `o_rsp_valid` pulse is produced;
  - the transaction is lost.
- Accept at edge k: cs_b low from edge k+1, and `o_req_ready` low from edge k+1.
- cs_b stays low for N + 16N + GAP_HP·N + 16N + N cycles.
  - Example: N=2, GAP_HP=4 gives 76 cycles.
- `o_rsp_valid` is high for exactly the first cycle of cs_b=1. `o_req_ready` returns N cycles later.
- All pin outputs are registered, so there are no glitches on SCK or CS_b.
- SCK duty cycle is exactly 50%.
- MOSI is stable for N cycles before and after each rising SCK edge.

## Structure
- Package `spi_cmd_pkg`:
  - command field positions (RW=7, SEL=6:5, IOC=4:0);
  - state encoding localparams;
  - `WR=1'b1`, `RD=1'b0`.
  - The responder-side logic imports the same package.
- One natural sub-module, `spi_byte_shift`:
  - 8-bit shift register with load, shift-out on fall, and shift-in on rise;
  - contains no timing logic.
- The top level owns the FSM, the divider and the counters.

## Test plan
- Reset then idle → `o_req_ready`=1; cs_b=1, sck=0, mosi=0 held for 100 cycles.
- Write, CLK_DIV=2, GAP_HP=4, rw=1, sel=2, ioc=0x05, data=0xA5:
  - MOSI bytes 0xC5 then 0xA5;
  - cs_b low for 76 cycles;
  - one rsp pulse with data 0x00;
  - 16 SCK rising edges.
- Read rw=0, sel=1, ioc=0x1F with a responder model driving 0x5A:
  - MOSI bytes 0x3F, 0x00;
  - `o_rsp_data`=0x5A.
- Back-to-back requests with `i_req_valid` held high:
  - second accept occurs exactly N cycles after the first rsp pulse;
  - cs_b high ≥ N cycles between transactions.
- `i_rst` asserted in the middle of byte 1 of a read:
  - pins reach reset values in the same cycle;
  - no rsp pulse;
  - next request completes normally.
- CLK_DIV=1, GAP_HP=1 corner, plus a request toggled during a busy period:
  - busy-period request ignored;
  - read of 0xFF / 0x00 data captured correctly.
